// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 message sequencer.
package sha256_pkg;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    PAD  = 2'd1,
    LEN  = 2'd2,
    EMIT = 2'd3
  } seq_state_t;

  localparam int         SHA_BLOCK_WORDS = 16;
  localparam int         SHA_LEN_WORDS   = 2;
  localparam logic [7:0] SHA_PAD_MARKER  = 8'h80;

  // Byte enables on a final word must be MSB-contiguous (or empty).
  function automatic logic keep_legal_last(input logic [3:0] keep);
    case (keep)
      4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000: return 1'b1;
      default:                                     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/sha256_tail_pad.sv
// Combinational formatter for the final word of a message: keeps the valid
// bytes, drops the 0x80 marker into the first free byte and zeroes the rest.
// A full final word cannot hold the marker, so it is flagged as pending.
module sha256_tail_pad
  import sha256_pkg::*;
(
  input  logic [31:0] data,
  input  logic [3:0]  keep,
  output logic [31:0] word,
  output logic        marker_pend,
  output logic [2:0]  nbytes,
  output logic        legal
);

  logic [3:0] keep_eff;

  // Illegal patterns are treated as a full word so the stream keeps moving.
  always_comb begin
    legal       = keep_legal_last(keep);
    keep_eff    = legal ? keep : 4'b1111;
    word        = data;
    marker_pend = 1'b0;
    nbytes      = 3'd4;
    case (keep_eff)
      4'b1110: begin word = {data[31:8],  SHA_PAD_MARKER};          nbytes = 3'd3; end
      4'b1100: begin word = {data[31:16], SHA_PAD_MARKER, 8'h00};   nbytes = 3'd2; end
      4'b1000: begin word = {data[31:24], SHA_PAD_MARKER, 16'h0};   nbytes = 3'd1; end
      4'b0000: begin word = {SHA_PAD_MARKER, 24'h0};                nbytes = 3'd0; end
      default: begin word = data; marker_pend = 1'b1;               nbytes = 3'd4; end
    endcase
  end

endmodule

// File: rtl/sha256_msg_sequencer.sv
// Packs a 32-bit message word stream into padded 512-bit SHA-256 blocks and
// hands them to the compression core over valid/ready.
// Optional block counter on blk_count_o: define SHA256_SEQ_STATS_EN.
module sha256_msg_sequencer
  import sha256_pkg::*;
#(
  parameter int BYTE_CNT_W = 61
) (
  input  logic         axi_clk_i,
  input  logic         aresetn_i,
  input  logic         s_valid_i,
  output logic         s_ready_o,
  input  logic [31:0]  s_data_i,
  input  logic [3:0]   s_keep_i,
  input  logic         s_last_i,
  output logic         blk_valid_o,
  input  logic         blk_ready_i,
  output logic [511:0] blk_data_o,
  output logic         blk_first_o,
  output logic         blk_last_o,
  output logic         msg_done_o,
  output logic         keep_err_o,
  input  logic         err_clr_i,
  output logic [31:0]  blk_count_o
);

  localparam logic [3:0] LAST_IDX = 4'(SHA_BLOCK_WORDS - 1);
  localparam logic [3:0] LEN_IDX  = 4'(SHA_BLOCK_WORDS - SHA_LEN_WORDS);

  seq_state_t            state, state_d;
  logic [3:0]            wr_idx, wr_idx_d;
  logic [BYTE_CNT_W-1:0] byte_cnt, byte_cnt_d;
  logic                  first_flag, first_flag_d;
  logic                  last_pend, last_pend_d;
  logic                  pad_pend, pad_pend_d;
  logic                  marker_pend, marker_pend_d;
  logic                  keep_err, keep_err_d;
  logic                  msg_done, msg_done_d;
  logic                  new_err;
  logic                  wr_en, len_wr, buf_clr;
  logic [31:0]           wr_word;
  logic [63:0]           bitlen;
  logic [31:0]           blk_buf [SHA_BLOCK_WORDS];

  logic [31:0]           tp_word;
  logic                  tp_marker;
  logic [2:0]            tp_nbytes;
  logic                  tp_legal;

  sha256_tail_pad u_tail_pad (
    .data        (s_data_i),
    .keep        (s_keep_i),
    .word        (tp_word),
    .marker_pend (tp_marker),
    .nbytes      (tp_nbytes),
    .legal       (tp_legal)
  );

  assign bitlen     = 64'({byte_cnt, 3'b000});
  assign msg_done_o = msg_done;
  assign keep_err_o = keep_err;

  // Next-state, buffer write controls and handshake outputs.
  always_comb begin
    state_d       = state;
    wr_idx_d      = wr_idx;
    byte_cnt_d    = byte_cnt;
    first_flag_d  = first_flag;
    last_pend_d   = last_pend;
    pad_pend_d    = pad_pend;
    marker_pend_d = marker_pend;
    new_err       = 1'b0;
    wr_en         = 1'b0;
    wr_word       = '0;
    len_wr        = 1'b0;
    buf_clr       = 1'b0;
    s_ready_o     = 1'b0;
    blk_valid_o   = 1'b0;
    blk_first_o   = 1'b0;
    blk_last_o    = 1'b0;
    case (state)
      FILL: begin
        s_ready_o = 1'b1;
        if (s_valid_i) begin
          wr_en    = 1'b1;
          wr_idx_d = wr_idx + 4'd1;
          if (s_last_i) begin
            wr_word       = tp_word;
            marker_pend_d = tp_marker;
            byte_cnt_d    = byte_cnt + BYTE_CNT_W'(tp_nbytes);
            new_err       = ~tp_legal;
            if (wr_idx == LAST_IDX) begin
              // Block is full: length (and maybe the marker) go to a fresh block.
              state_d     = EMIT;
              pad_pend_d  = 1'b1;
              last_pend_d = 1'b0;
            end else begin
              state_d = PAD;
            end
          end else begin
            wr_word    = s_data_i;
            byte_cnt_d = byte_cnt + BYTE_CNT_W'(4);
            new_err    = (s_keep_i != 4'b1111);
            if (wr_idx == LAST_IDX) begin
              state_d     = EMIT;
              last_pend_d = 1'b0;
              pad_pend_d  = 1'b0;
            end
          end
        end
      end
      PAD: begin
        if (wr_idx == LEN_IDX && !marker_pend) begin
          state_d = LEN;
        end else begin
          wr_en         = 1'b1;
          wr_word       = marker_pend ? {SHA_PAD_MARKER, 24'h0} : 32'h0;
          marker_pend_d = 1'b0;
          wr_idx_d      = wr_idx + 4'd1;
          if (wr_idx == LAST_IDX) begin
            // No room left for the length words in this block.
            state_d     = EMIT;
            pad_pend_d  = 1'b1;
            last_pend_d = 1'b0;
          end else if (wr_idx == LEN_IDX - 4'd1) begin
            state_d = LEN;
          end
        end
      end
      LEN: begin
        len_wr      = 1'b1;
        state_d     = EMIT;
        last_pend_d = 1'b1;
        pad_pend_d  = 1'b0;
      end
      EMIT: begin
        blk_valid_o = 1'b1;
        blk_first_o = first_flag;
        blk_last_o  = last_pend;
        if (blk_ready_i) begin
          wr_idx_d     = '0;
          first_flag_d = 1'b0;
          if (last_pend) begin
            byte_cnt_d   = '0;
            first_flag_d = 1'b1;
            last_pend_d  = 1'b0;
            buf_clr      = 1'b1;
            state_d      = FILL;
          end else if (pad_pend) begin
            pad_pend_d = 1'b0;
            state_d    = PAD;
          end else begin
            state_d = FILL;
          end
        end
      end
      default: state_d = FILL;
    endcase
    keep_err_d = new_err ? 1'b1 : (err_clr_i ? 1'b0 : keep_err);
    msg_done_d = (state == EMIT) && blk_ready_i && last_pend;
  end

  // Control and state registers.
  always_ff @(posedge axi_clk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      state       <= FILL;
      wr_idx      <= '0;
      byte_cnt    <= '0;
      first_flag  <= 1'b1;
      last_pend   <= 1'b0;
      pad_pend    <= 1'b0;
      marker_pend <= 1'b0;
      keep_err    <= 1'b0;
      msg_done    <= 1'b0;
    end else begin
      state       <= state_d;
      wr_idx      <= wr_idx_d;
      byte_cnt    <= byte_cnt_d;
      first_flag  <= first_flag_d;
      last_pend   <= last_pend_d;
      pad_pend    <= pad_pend_d;
      marker_pend <= marker_pend_d;
      keep_err    <= keep_err_d;
      msg_done    <= msg_done_d;
    end
  end

  // Block buffer: single-word writes while filling/padding, two-word length write.
  always_ff @(posedge axi_clk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      for (int i = 0; i < SHA_BLOCK_WORDS; i++) blk_buf[i] <= '0;
    end else if (buf_clr) begin
      for (int i = 0; i < SHA_BLOCK_WORDS; i++) blk_buf[i] <= '0;
    end else begin
      if (wr_en) blk_buf[wr_idx] <= wr_word;
      if (len_wr) begin
        blk_buf[LEN_IDX]  <= bitlen[63:32];
        blk_buf[LAST_IDX] <= bitlen[31:0];
      end
    end
  end

  // Flatten the buffer onto the block bus only while a block is offered.
  always_comb begin
    blk_data_o = '0;
    if (state == EMIT) begin
      for (int i = 0; i < SHA_BLOCK_WORDS; i++)
        blk_data_o[32*(SHA_BLOCK_WORDS-1-i) +: 32] = blk_buf[i];
    end
  end

`ifdef SHA256_SEQ_STATS_EN
  logic [31:0] blk_count;

  // Saturating count of accepted blocks.
  always_ff @(posedge axi_clk_i or negedge aresetn_i) begin
    if (!aresetn_i)
      blk_count <= '0;
    else if (state == EMIT && blk_ready_i && blk_count != 32'hFFFF_FFFF)
      blk_count <= blk_count + 32'd1;
  end

  assign blk_count_o = blk_count;
`else
  assign blk_count_o = '0;
`endif

endmodule

// File: doc/sha256_msg_sequencer.md
Name: sha256_msg_sequencer

Overview:
- Streams 32-bit message words into 512-bit SHA-256 blocks for the compression core in `sha256_processing`.
- Applies FIPS 180-4 padding and the 64-bit big-endian length field.
- Presents each block to the core over a valid/ready handshake and flags the first block of each message so the core reloads its initial hash.
- Sits between the AXI-Lite register front end and the compression datapath, replacing software-side padding.

Parameters:
- BYTE_CNT_W, 61, width of the message byte counter. Bit length = bytes*8, zero-extended to 64 bits in the length field.

Ports:
- axi_clk_i  in  1  single clock
- aresetn_i  in  1  reset, asynchronous, active-low
- s_valid_i  in  1  message word valid
- s_ready_o  out  1  sequencer accepts word
- s_data_i  in  32  message word, byte 0 at [31:24]
- s_keep_i  in  4  byte enables, MSB-contiguous
- s_last_i  in  1  final word of message
- blk_valid_o  out  1  block available to core
- blk_ready_i  in  1  core accepts block
- blk_data_o  out  512  block, word 0 at [511:480]
- blk_first_o  out  1  block is first of its message
- blk_last_o  out  1  block is final (padded) block
- msg_done_o  out  1  one-cycle pulse when the final block is accepted
- keep_err_o  out  1  sticky; illegal keep seen
- err_clr_i  in  1  clears keep_err_o
- blk_count_o  out  32  emitted-block count (optional feature)

Behaviour:
- Reset (async assert, sync release): state=FILL, wr_idx=0, byte_cnt=0, first_flag=1, buffer=0. All outputs 0 except s_ready_o=1.
- Buffer: 16x32 words, write index wr_idx 0..15.
- FILL:
  - s_ready_o=1. A word is accepted when s_valid_i&s_ready_o.
  - Non-last word: requires keep=1111. It is written to buf[wr_idx], byte_cnt+=4, wr_idx++. When wr_idx wraps 15->0 the next state is EMIT with last_pend=0.
  - Last word: legal keep values are 1111, 1110, 1100, 1000, 0000. Valid bytes are kept; the first invalid byte position gets 0x80 and the rest are zeroed. If keep=1111, the word is written unchanged and 0x80000000 is queued for the next index. byte_cnt is incremented by popcount(keep). Next state is PAD.
  - Illegal keep (non-1111 on a non-last word, or a non-contiguous pattern): set keep_err_o. The word is still accepted as if keep=1111 (last) or unchanged (non-last). The sequencer never stalls on an error.
- PAD: s_ready_o=0. One zero word is written per cycle until wr_idx==14.
  - If wr_idx>14 when PAD is entered, or the marker word must land at index 15, zero-fill to 15 and go to EMIT with pad_pend=1. The next block is then all zeros plus the length.
  - A 0x80 marker still queued when the block wraps goes to word 0 of the next block.
- LEN: buf[14]=bitlen[63:32] and buf[15]=bitlen[31:0] are written in one cycle. Go to EMIT with last_pend=1.
- EMIT:
  - blk_valid_o=1 and blk_data_o=buffer, held stable until blk_ready_i.
  - blk_first_o=first_flag; blk_last_o=last_pend.
  - On accept: wr_idx=0 and first_flag=0.
    - If last_pend: msg_done_o pulses the next cycle, byte_cnt=0, first_flag=1, buffer cleared, next state FILL.
    - If pad_pend: next state PAD.
    - Otherwise: next state FILL.
- Latency: word accept to block valid is 1 cycle (full block) or ≤15 cycles (padding path).
- Simultaneous err_clr_i and a new error: the error wins.
- byte_cnt wraps modulo 2^BYTE_CNT_W and is not checked.
- Reset mid-EMIT: blk_valid_o drops immediately (async). The partial message is discarded and the next message starts with first=1.

Optional Feature:
- Macro: SHA256_SEQ_STATS_EN.
- Defined: blk_count_o increments on every block handshake, saturates at 0xFFFFFFFF, and resets to 0.
- Undefined: blk_count_o is tied to 0 and no counter logic is synthesised.

Decomposition:
- Package sha256_pkg:
  - seq_state_t enum (FILL, PAD, LEN, EMIT)
  - SHA_BLOCK_WORDS=16, SHA_LEN_WORDS=2, SHA_PAD_MARKER=8'h80
  - keep_legal_last() function
- Sub-module sha256_tail_pad: combinational last-word formatter. Takes data+keep and returns the padded word, a marker-pending flag, the byte count and a legality flag.

Test Plan:
- "abc" (0x61626300, keep 1110, last) -> one block: word0=0x61626380, words1-14=0, word15=0x00000018, first=1, last=1; msg_done pulse.
- 14 full words (56 bytes), last -> block A: words0-13 data, word14=0x80000000, word15=0, last=0. Block B: words0-14=0, word15=0x000001C0, last=1.
- 16 full words (64 bytes) -> block A all data, first=1, last=0. Block B: word0=0x80000000, word15=0x00000200, first=0, last=1.
- Empty message (keep 0000, last) -> word0=0x80000000, word15=0; blk_ready_i held low 10 cycles keeps blk_data_o stable.
- keep=1100 on a non-last word -> keep_err_o=1, sticky until err_clr_i; with simultaneous new error it stays 1.
- Deassert aresetn_i during EMIT of block 2 of 2 -> outputs clear asynchronously; the following "abc" message gives the block in scenario 1 with first=1.
